// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, credit-limited imem requests, {inst,pc} buffer to decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        id_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_inst [DEPTH];

    logic [CW:0]   w_credit_used;
    logic          w_req;
    logic          w_grant;
    logic          w_rsp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic [CW-1:0] w_out_after_rsp;
    logic [31:0]   w_redirect_pc;
    logic          w_unused_pc_lsb;

    // Credit covers both in-flight and buffered words, so a returning word always has a slot.
    assign w_credit_used   = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req           = clrn & ~redirect & (w_credit_used < {1'b0, DEPTH_C});
    assign w_grant         = w_req & imem_gnt;
    assign w_rsp           = imem_rvalid & (r_outstanding != '0);
    assign w_drop          = w_rsp & (r_discard != '0);
    assign w_push          = w_rsp & ~w_drop;
    assign w_nonempty      = (r_count != '0);
    assign w_pop           = id_valid & id_ready;
    assign w_out_after_rsp = r_outstanding - CW'(w_rsp);
    assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign id_valid  = clrn & w_nonempty;
    assign id_inst   = id_valid ? r_fifo_inst[r_rptr] : 32'h0;
    assign id_pc     = id_valid ? r_fifo_pc[r_rptr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else if (redirect) begin
            // Everything still in flight after this cycle's response belongs to the old path.
            r_pc          <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_outstanding <= w_out_after_rsp;
            r_discard     <= w_out_after_rsp;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            if (w_grant) begin
                r_pc <= r_pc + 32'd4;
            end
            r_outstanding <= w_out_after_rsp + CW'(w_grant);
            if (w_drop) begin
                r_discard <= r_discard - CW'(1);
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
                r_wptr   <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (clrn && !redirect && w_push) begin
            r_fifo_pc[r_wptr]   <= r_rsp_pc;
            r_fifo_inst[r_wptr] <= imem_rdata;
        end
    end
endmodule
